vu_frame_ctrl: RTL and testbench

//  Frame-synchronous VU-meter controller. Sits between the audio level source and the VGA timing generator.

---
 rtl/vu_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_vu_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_frame_ctrl.sv
// Frame-synchronous VU-meter controller: per-frame max of handshaked level samples,
// committed during vertical sync, with peak-hold/decay and registered 3/3/2 bar rendering.
module vu_frame_ctrl #(
  parameter int unsigned BAR_Y0     = 200,
  parameter int unsigned BAR_H      = 80,
  parameter int unsigned PEAK_HOLD  = 30,
  parameter int unsigned DECAY_STEP = 4,
  parameter int unsigned YEL_X      = 400,
  parameter int unsigned RED_X      = 520
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lvl_valid,
  input  logic [7:0] lvl_data,
  output logic       lvl_ready,
  input  logic       vs,
  input  logic       de,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE,
  output logic       frame_tick
);

  localparam int unsigned HW = (PEAK_HOLD < 2) ? 1 : $clog2(PEAK_HOLD + 1);

  localparam logic [9:0]    ROW_LO    = 10'(BAR_Y0);
  localparam logic [9:0]    ROW_HI    = 10'(BAR_Y0 + BAR_H - 1);
  localparam logic [9:0]    YEL_COL   = 10'(YEL_X);
  localparam logic [9:0]    RED_COL   = 10'(RED_X);
  localparam logic [HW-1:0] HOLD_INIT = HW'(PEAK_HOLD);
  localparam logic [7:0]    DEC       = 8'(DECAY_STEP);

  localparam logic [7:0] C_BLACK  = 8'b000_000_00;
  localparam logic [7:0] C_WHITE  = 8'b111_111_11;
  localparam logic [7:0] C_RED    = 8'b111_000_00;
  localparam logic [7:0] C_YELLOW = 8'b111_111_00;
  localparam logic [7:0] C_GREEN  = 8'b000_111_00;
  localparam logic [7:0] C_GREY   = 8'b001_001_00;

  typedef enum logic [1:0] {
    S_WAIT_VS,
    S_ACCUM,
    S_COMMIT,
    S_PEAK
  } state_t;

  state_t          state_q, state_d;
  logic            vs_q;
  logic [7:0]      acc_q,  acc_d;
  logic [7:0]      bar_q,  bar_d;
  logic [7:0]      peak_q, peak_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [7:0]      rgb_q,  rgb_d;

  logic            fall;
  logic            xfer;
  logic [7:0]      peak_dec;
  logic [9:0]      bar_px;
  logic [9:0]      peak_px;
  logic [9:0]      peak_end;
  logic            in_rows;
  logic            on_marker;
  logic            lit;

  assign fall       = vs_q & ~vs;
  assign lvl_ready  = (state_q == S_ACCUM);
  assign xfer       = lvl_valid & lvl_ready;
  assign frame_tick = (state_q == S_COMMIT);
  assign peak_dec   = (peak_q > DEC) ? (peak_q - DEC) : '0;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bar_d   = bar_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    case (state_q)
      S_ACCUM: begin
        // A sample arriving on the fall cycle still lands in this frame's max.
        if (xfer && (lvl_data > acc_q)) acc_d = lvl_data;
        if (fall) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        bar_d   = acc_q;
        acc_d   = '0;
        state_d = S_PEAK;
      end
      S_PEAK: begin
        if (bar_q >= peak_q) begin
          peak_d = bar_q;
          hold_d = HOLD_INIT;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          peak_d = (peak_dec > bar_q) ? peak_dec : bar_q;
        end
        state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs) state_d = S_ACCUM;
      end
      default: state_d = S_WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_WAIT_VS;
      vs_q    <= 1'b1;
      acc_q   <= '0;
      bar_q   <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs;
      acc_q   <= acc_d;
      bar_q   <= bar_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
    end
  end

  // Level to pixels is x2.5 (255 -> 637), kept within 10 bits.
  assign bar_px    = {1'b0, bar_q, 1'b0} + {3'b000, bar_q[7:1]};
  assign peak_px   = {1'b0, peak_q, 1'b0} + {3'b000, peak_q[7:1]};
  assign peak_end  = peak_px + 10'd3;
  assign in_rows   = (px_y >= ROW_LO) && (px_y <= ROW_HI);
  assign on_marker = (peak_q != '0) && (px_x >= peak_px) && (px_x <= peak_end);
  assign lit       = (px_x < bar_px);

  always_comb begin
    rgb_d = C_GREY;
    if (!de || !in_rows)                rgb_d = C_BLACK;
    else if (on_marker)                 rgb_d = C_WHITE;
    else if (lit && (px_x >= RED_COL))  rgb_d = C_RED;
    else if (lit && (px_x >= YEL_COL))  rgb_d = C_YELLOW;
    else if (lit)                       rgb_d = C_GREEN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= rgb_d;
  end

  assign {RED, GREEN, BLUE} = rgb_q;

endmodule

// File: tb/tb_vu_frame_ctrl.sv
// Self-checking bench for vu_frame_ctrl: directed scenarios plus random frames
// compared against a frame-level behavioural model.
module tb_vu_frame_ctrl;

  localparam logic [7:0] BLACK  = 8'b000_000_00;
  localparam logic [7:0] WHITE  = 8'b111_111_11;
  localparam logic [7:0] REDC   = 8'b111_000_00;
  localparam logic [7:0] YELLOW = 8'b111_111_00;
  localparam logic [7:0] GREENC = 8'b000_111_00;
  localparam logic [7:0] GREY   = 8'b001_001_00;

  logic       clk;
  logic       rst;
  logic       lvl_valid;
  logic [7:0] lvl_data;
  logic       lvl_ready;
  logic       vs;
  logic       de;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic [2:0] RED;
  logic [2:0] GREEN;
  logic [1:0] BLUE;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int tick_cnt;

  // frame-level reference state
  int macc, mbar, mpeak, mhold;

  vu_frame_ctrl #(
    .BAR_Y0(200), .BAR_H(80), .PEAK_HOLD(30), .DECAY_STEP(4), .YEL_X(400), .RED_X(520)
  ) dut (
    .clk(clk), .rst(rst), .lvl_valid(lvl_valid), .lvl_data(lvl_data), .lvl_ready(lvl_ready),
    .vs(vs), .de(de), .px_x(px_x), .px_y(px_y),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_reset();
    macc = 0; mbar = 0; mpeak = 0; mhold = 0;
  endtask

  task automatic model_commit();
    int dec;
    mbar = macc;
    macc = 0;
    if (mbar >= mpeak) begin
      mpeak = mbar;
      mhold = 30;
    end else if (mhold > 0) begin
      mhold = mhold - 1;
    end else begin
      dec   = (mpeak > 4) ? mpeak - 4 : 0;
      mpeak = (dec > mbar) ? dec : mbar;
    end
  endtask

  function automatic logic [7:0] model_rgb(input int x, input int y, input bit d);
    int bpx, ppx;
    bpx = 2 * mbar + mbar / 2;
    ppx = 2 * mpeak + mpeak / 2;
    if (!d || y < 200 || y > 279) return BLACK;
    if (mpeak != 0 && x >= ppx && x <= ppx + 3) return WHITE;
    if (x < bpx) begin
      if (x >= 520) return REDC;
      if (x >= 400) return YELLOW;
      return GREENC;
    end
    return GREY;
  endfunction

  task automatic px_chk(input string tag, input int x, input int y, input bit d,
                        input logic [7:0] exp);
    de = d; px_x = 10'(x); px_y = 10'(y);
    tick();
    chk(tag, {24'd0, RED, GREEN, BLUE}, {24'd0, exp});
    de = 1'b0;
  endtask

  task automatic px_model(input string tag, input int x, input int y, input bit d);
    px_chk(tag, x, y, d, model_rgb(x, y, d));
  endtask

  task automatic send(input logic [7:0] v);
    bit done, r;
    done = 1'b0;
    lvl_valid = 1'b1; lvl_data = v;
    for (int i = 0; i < 20 && !done; i++) begin
      r = lvl_ready;
      tick();
      if (r) done = 1'b1;
    end
    lvl_valid = 1'b0;
    if (done) begin
      if (int'(v) > macc) macc = int'(v);
    end else begin
      checks++; errors++;
      $error("FAIL send_timeout: observed no transfer expected transfer within 20 cycles");
    end
  endtask

  // vs goes low for 5 cycles: fall, commit, peak update, then waiting in sync
  task automatic frame_fall(input bit with_s, input logic [7:0] s);
    tick_cnt = 0;
    if (with_s) begin
      lvl_valid = 1'b1; lvl_data = s;
      if (int'(s) > macc) macc = int'(s);
    end
    vs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      lvl_valid = 1'b0;
      tick_cnt += int'(frame_tick);
    end
    model_commit();
  endtask

  task automatic frame_rise();
    vs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tick_cnt += int'(frame_tick);
    end
  endtask

  task automatic frame(input bit with_s, input logic [7:0] s);
    frame_fall(with_s, s);
    frame_rise();
  endtask

  initial begin
    int n, x, y;
    logic [7:0] v;
    rst = 1'b0; vs = 1'b1; de = 1'b1; px_x = 10'd0; px_y = 10'd220;
    lvl_valid = 1'b0; lvl_data = 8'd0;
    model_reset();

    // reset state
    tick(); tick(); tick();
    chk("reset_rgb", {24'd0, RED, GREEN, BLUE}, 32'd0);
    chk("reset_tick", {31'd0, frame_tick}, 32'd0);
    chk("reset_ready", {31'd0, lvl_ready}, 32'd0);
    de = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("ready_after_release", {31'd0, lvl_ready}, 32'd1);

    // samples 10, 200, 50 in one frame
    send(8'd10); send(8'd200); send(8'd50);
    frame(1'b0, 8'd0);
    chk("f200_tick_count", tick_cnt, 32'd1);
    px_chk("f200_px499_yellow", 499, 220, 1'b1, YELLOW);
    px_chk("f200_px500_white",  500, 220, 1'b1, WHITE);
    px_chk("f200_px503_white",  503, 220, 1'b1, WHITE);
    px_chk("f200_px504_grey",   504, 220, 1'b1, GREY);
    px_chk("f200_px100_green",  100, 220, 1'b1, GREENC);
    px_chk("f200_px400_yellow", 400, 220, 1'b1, YELLOW);
    px_chk("f200_px399_green",  399, 220, 1'b1, GREENC);
    px_chk("row199_black",      100, 199, 1'b1, BLACK);
    px_chk("row200_green",      100, 200, 1'b1, GREENC);
    px_chk("row279_green",      100, 279, 1'b1, GREENC);
    px_chk("row280_black",      100, 280, 1'b1, BLACK);
    px_chk("de0_black",         100, 220, 1'b0, BLACK);

    // peak hold for 30 frames, then decay
    for (int f = 0; f < 30; f++) frame(1'b0, 8'd0);
    px_chk("hold30_px500_white", 500, 220, 1'b1, WHITE);
    px_chk("hold30_px0_grey",      0, 220, 1'b1, GREY);
    frame(1'b0, 8'd0);
    px_chk("decay196_px490_white", 490, 220, 1'b1, WHITE);
    px_chk("decay196_px500_grey",  500, 220, 1'b1, GREY);
    frame(1'b0, 8'd0);
    px_chk("decay192_px480_white", 480, 220, 1'b1, WHITE);
    px_chk("decay192_px490_grey",  490, 220, 1'b1, GREY);
    px_chk("decay192_px0_grey",      0, 220, 1'b1, GREY);
    px_model("decay192_model", 479, 220, 1'b1);

    // sample offered while vs low is held off until accumulation resumes
    frame_fall(1'b0, 8'd0);
    lvl_valid = 1'b1; lvl_data = 8'd90;
    for (int i = 0; i < 3; i++) begin
      chk("vslow_ready", {31'd0, lvl_ready}, 32'd0);
      tick();
    end
    frame_rise();
    send(8'd90);
    frame(1'b0, 8'd0);
    chk("f90_tick_count", tick_cnt, 32'd1);
    px_chk("f90_px224_green", 224, 220, 1'b1, GREENC);
    px_chk("f90_px225_grey",  225, 220, 1'b1, GREY);
    px_model("f90_model_peak", 2 * mpeak + mpeak / 2, 220, 1'b1);

    // sample transferred in the exact vs-fall cycle
    frame(1'b1, 8'd250);
    chk("f250_tick_count", tick_cnt, 32'd1);
    px_chk("f250_px624_red",   624, 220, 1'b1, REDC);
    px_chk("f250_px625_white", 625, 220, 1'b1, WHITE);
    px_chk("f250_px628_white", 628, 220, 1'b1, WHITE);
    px_chk("f250_px629_grey",  629, 220, 1'b1, GREY);
    px_chk("f250_px520_red",   520, 220, 1'b1, REDC);
    px_chk("f250_px519_yellow",519, 220, 1'b1, YELLOW);

    // mid-frame reset with acc holding 180
    send(8'd180);
    de = 1'b1; px_x = 10'd0; px_y = 10'd220;
    tick();
    chk("pre_reset_green", {24'd0, RED, GREEN, BLUE}, {24'd0, GREENC});
    rst = 1'b0;
    #1;
    chk("async_reset_rgb", {24'd0, RED, GREEN, BLUE}, 32'd0);
    chk("async_reset_ready", {31'd0, lvl_ready}, 32'd0);
    model_reset();
    vs = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tick_cnt += int'(frame_tick);
    end
    chk("post_reset_no_tick", tick_cnt, 32'd0);
    chk("post_reset_vslow_ready", {31'd0, lvl_ready}, 32'd0);
    de = 1'b0;
    frame_rise();
    chk("post_reset_ready", {31'd0, lvl_ready}, 32'd1);
    px_chk("post_reset_px0_grey", 0, 220, 1'b1, GREY);
    frame(1'b0, 8'd0);
    chk("post_reset_tick_count", tick_cnt, 32'd1);
    px_chk("post_reset_acc_cleared", 0, 220, 1'b1, GREY);

    // random frames against the model
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0:       v = 8'd255;
          1:       v = 8'd0;
          default: v = 8'($urandom_range(0, 255));
        endcase
        send(v);
      end
      if ($urandom_range(0, 3) == 0) frame(1'b1, 8'($urandom_range(0, 255)));
      else                           frame(1'b0, 8'd0);
      chk("rand_tick_count", tick_cnt, 32'd1);
      px_model("rand_peak_px", 2 * mpeak + mpeak / 2, 220, 1'b1);
      px_model("rand_bar_edge", (2 * mbar + mbar / 2 > 0) ? 2 * mbar + mbar / 2 - 1 : 0, 240, 1'b1);
      for (int k = 0; k < 4; k++) begin
        x = $urandom_range(0, 639);
        case ($urandom_range(0, 4))
          0:       y = 199;
          1:       y = 280;
          2:       y = 200;
          3:       y = 279;
          default: y = $urandom_range(0, 479);
        endcase
        px_model("rand_px", x, y, $urandom_range(0, 7) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
